// File: rtl/fsm_driver_pkg.sv
// Shared definitions for the plant steering driver: plant state encodings
// (identical to the steered plant FSM's {a,b}) and the driver's own states.
package fsm_driver_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } plant_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEER = 2'b01,
    RESP  = 2'b10
  } drv_state_t;

  localparam int HOP_W = 3;

endpackage

// File: rtl/fsm_nexthop.sv
// Combinational next-hop table: the x/y pair that moves the plant one step
// closer to the target from its current state.
module fsm_nexthop
  import fsm_driver_pkg::*;
(
  input  plant_state_t target,
  input  plant_state_t current,
  output logic         x,
  output logic         y
);

  // S2 is never a valid target (nothing reaches it), so it falls to the default.
  always_comb begin
    x = 1'b0;
    y = 1'b0;
    case (target)
      S0: begin
        case (current)
          S1, S2:  x = 1'b1;
          default: ;
        endcase
      end
      S1: begin
        case (current)
          S0, S2:  x = 1'b1;
          default: ;
        endcase
      end
      S3: begin
        case (current)
          S0:      x = 1'b1;
          S1:      y = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_driver.sv
// Request/response driver that steers an external plant FSM to a requested
// state via x/y, counting steering cycles and reporting timeout/unreachable.
module fsm_driver
  import fsm_driver_pkg::*;
#(
  parameter int MAX_HOPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_target,
  input  logic [1:0]       fb_state,
  output logic             x,
  output logic             y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  output logic [HOP_W-1:0] resp_hops
);

  localparam logic [HOP_W-1:0] HOP_LIMIT = HOP_W'(MAX_HOPS);

  drv_state_t       state, state_next;
  plant_state_t     target_q, target_next;
  plant_state_t     fb, req_tgt;
  logic [HOP_W-1:0] hops_q, hops_next;
  logic             err_q, err_next;
  logic             hop_x, hop_y;

  assign fb      = plant_state_t'(fb_state);
  assign req_tgt = plant_state_t'(req_target);

  fsm_nexthop u_nexthop (
    .target  (target_q),
    .current (fb),
    .x       (hop_x),
    .y       (hop_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target_q <= S0;
      hops_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      target_q <= target_next;
      hops_q   <= hops_next;
      err_q    <= err_next;
    end
  end

  // hops_q doubles as the live step counter in STEER and the reported count in RESP.
  always_comb begin
    state_next  = state;
    target_next = target_q;
    hops_next   = hops_q;
    err_next    = err_q;
    x           = 1'b0;
    y           = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          target_next = req_tgt;
          hops_next   = '0;
          err_next    = 1'b0;
          if (req_tgt == S2) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else if (fb == req_tgt) begin
            state_next = RESP;
          end else begin
            state_next = STEER;
          end
        end
      end
      STEER: begin
        if (fb == target_q) begin
          err_next   = 1'b0;
          state_next = RESP;
        end else if (hops_q >= HOP_LIMIT) begin
          err_next   = 1'b1;
          hops_next  = HOP_LIMIT;
          state_next = RESP;
        end else begin
          x         = hop_x;
          y         = hop_y;
          hops_next = hops_q + 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result fields read as zero outside RESP so the counter never leaks out.
  assign resp_err  = (state == RESP) ? err_q : 1'b0;
  assign resp_hops = (state == RESP) ? hops_q : '0;

endmodule
